uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 13 +
 rtl/rr_pick.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitBusy,
        StWaitDone
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping to 0.
module rr_pick #(
    parameter int unsigned N = 2,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = IW'((32'(ptr) + i) % N);
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding bytes from several requesters to one UART transmitter.
// Define UART_ARB_PKT_LOCK_EN to hold the grant on one requester until its req_last byte.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned REQ_NUM   = 2,
    parameter int unsigned BUSY_WAIT = 4,
    localparam int unsigned IDW      = $clog2(REQ_NUM)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REQ_NUM-1:0]        req_valid,
    input  logic [REQ_NUM*BYTE_W-1:0] req_data,
    input  logic [REQ_NUM-1:0]        req_last,
    output logic [REQ_NUM-1:0]        req_ready,
    output logic [IDW-1:0]            grant_id,
    output logic                      send_en,
    output logic [BYTE_W-1:0]         send_data,
    input  logic                      send_busy,
    output logic                      arb_busy
);

    localparam int unsigned CW = $clog2(BUSY_WAIT + 1);

    arb_state_t        state_q;
    logic [IDW-1:0]    ptr_q;
    logic [IDW-1:0]    grant_q;
    logic              send_en_q;
    logic [BYTE_W-1:0] data_q;
    logic              arb_busy_q;
    logic [CW-1:0]     cnt_q;

    logic [REQ_NUM-1:0] cand_req;
    logic [REQ_NUM-1:0] pick_gnt;
    logic [IDW-1:0]     pick_idx;
    logic               pick_any;
    logic               can_accept;
    logic               xfer;
    logic [BYTE_W-1:0]  win_data;
    logic [IDW-1:0]     ptr_next;

`ifdef UART_ARB_PKT_LOCK_EN
    logic               lock_q;
    logic [IDW-1:0]     lock_id_q;
    logic [REQ_NUM-1:0] lock_mask;

    // While a packet is open only its owner may be picked; others wait.
    always_comb begin
        lock_mask            = '0;
        lock_mask[lock_id_q] = 1'b1;
        cand_req             = lock_q ? (req_valid & lock_mask) : req_valid;
    end
`else
    logic unused_last;
    assign unused_last = ^req_last;
    assign cand_req    = req_valid;
`endif

    rr_pick #(
        .N(REQ_NUM)
    ) u_pick (
        .req(cand_req),
        .ptr(ptr_q),
        .gnt(pick_gnt),
        .idx(pick_idx),
        .any(pick_any)
    );

    // Gating with rst_n keeps the accept strobe quiet while reset is held.
    assign can_accept = rst_n && (state_q == StIdle) && !send_busy;
    assign req_ready  = can_accept ? pick_gnt : '0;
    assign xfer       = can_accept && pick_any;
    assign ptr_next   = (32'(pick_idx) == REQ_NUM - 1) ? '0 : pick_idx + 1'b1;

    always_comb begin
        win_data = '0;
        for (int unsigned i = 0; i < REQ_NUM; i++) begin
            if (pick_gnt[i]) begin
                win_data = win_data | req_data[i*BYTE_W +: BYTE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            grant_q    <= '0;
            send_en_q  <= 1'b0;
            data_q     <= '0;
            arb_busy_q <= 1'b0;
            cnt_q      <= '0;
`ifdef UART_ARB_PKT_LOCK_EN
            lock_q     <= 1'b0;
            lock_id_q  <= '0;
`endif
        end else begin
            send_en_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (xfer) begin
                        data_q     <= win_data;
                        grant_q    <= pick_idx;
                        ptr_q      <= ptr_next;
                        send_en_q  <= 1'b1;
                        arb_busy_q <= 1'b1;
                        state_q    <= StIssue;
`ifdef UART_ARB_PKT_LOCK_EN
                        lock_q     <= ~|(req_last & pick_gnt);
                        lock_id_q  <= pick_idx;
`endif
                    end
                end
                StIssue: begin
                    cnt_q   <= '0;
                    state_q <= StWaitBusy;
                end
                StWaitBusy: begin
                    // Give up waiting for busy after BUSY_WAIT cycles so a silent UART cannot stall us.
                    if (send_busy || cnt_q == CW'(BUSY_WAIT - 1)) begin
                        state_q <= StWaitDone;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StWaitDone: begin
                    if (!send_busy) begin
                        arb_busy_q <= 1'b0;
                        state_q    <= StIdle;
                    end
                end
                default: begin
                    arb_busy_q <= 1'b0;
                    state_q    <= StIdle;
                end
            endcase
        end
    end

    assign grant_id  = grant_q;
    assign send_en   = send_en_q;
    assign send_data = data_q;
    assign arb_busy  = arb_busy_q;

endmodule
